// File: rtl/aes_lite_pkg.sv
// Shared constants and types for the AES-lite result path.
package aes_lite_pkg;

  localparam int AES_LITE_DATA_W     = 8;
  localparam int AES_LITE_FIFO_DEPTH = 4;

  // Occupancy class of the result FIFO: empty, some entries, or every slot used.
  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/aes_lite_fifo_mem.sv
// DEPTH x DATA_W register array with one write port and an asynchronous read.
// Contents are not reset; the owner qualifies the read data with its own valid.
module aes_lite_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  entry_we;

  // One write-enable per entry, decoded from the write address.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign entry_we[gi] = wr_en && (wr_addr == PTR_W'(gi));
    end
  endgenerate

  // Capture the write data into the addressed entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_we[i]) begin
        mem_reg[i] <= wr_data;
      end
    end
  end

  // Head entry is visible combinationally (first-word fall-through).
  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/aes_lite_result_fifo.sv
// Result FIFO behind the AES-lite core: pushes one byte per rising edge of
// the core's ready level, drops on full (sticky overflow), and keeps a
// running XOR of every byte handed to the consumer.
module aes_lite_result_fifo
  import aes_lite_pkg::*;
#(
  parameter int DATA_W = AES_LITE_DATA_W,
  parameter int DEPTH  = AES_LITE_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] chk
);

  logic              res_ready_prev_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [LVL_W-1:0]  level_reg, level_next;
  logic              overflow_reg, overflow_next;
  logic [DATA_W-1:0] chk_reg, chk_next;
  fifo_state_t       state_reg, state_next;

  logic push_req;
  logic do_pop;
  logic is_full;
  logic do_write;
  logic do_drop;

  // The previous-ready register powers up high so a level already asserted
  // when reset releases is not mistaken for a new result.
  assign push_req  = res_ready && !res_ready_prev_reg;
  assign out_valid = (state_reg != FIFO_EMPTY);
  assign is_full   = (state_reg == FIFO_FULL);
  assign do_pop    = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_write  = push_req && (!is_full || do_pop);
  assign do_drop   = push_req && is_full && !do_pop;

  // Next values for occupancy, sticky overflow (set beats clear) and checksum.
  always_comb begin
    level_next    = level_reg + LVL_W'(do_write) - LVL_W'(do_pop);
    overflow_next = overflow_reg;
    if (do_drop) begin
      overflow_next = 1'b1;
    end else if (clr_ovf) begin
      overflow_next = 1'b0;
    end
    chk_next = do_pop ? (chk_reg ^ out_data) : chk_reg;
  end

  // Edge detect, pointers, level, flags and checksum registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_ready_prev_reg <= 1'b1;
      wr_ptr_reg         <= '0;
      rd_ptr_reg         <= '0;
      level_reg          <= '0;
      overflow_reg       <= 1'b0;
      chk_reg            <= '0;
    end else begin
      res_ready_prev_reg <= res_ready;
      if (do_write) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      level_reg    <= level_next;
      overflow_reg <= overflow_next;
      chk_reg      <= chk_next;
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FIFO_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Occupancy state follows the next level; EMPTY reaches FULL only via PARTIAL.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FIFO_EMPTY: begin
        if (level_next != '0) state_next = FIFO_PARTIAL;
      end
      FIFO_PARTIAL: begin
        if (level_next == '0)                 state_next = FIFO_EMPTY;
        else if (level_next == LVL_W'(DEPTH)) state_next = FIFO_FULL;
      end
      FIFO_FULL: begin
        if (level_next != LVL_W'(DEPTH)) state_next = FIFO_PARTIAL;
      end
      default: state_next = FIFO_EMPTY;
    endcase
  end

  aes_lite_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (do_write && !rst),
    .wr_addr (wr_ptr_reg),
    .wr_data (res_data),
    .rd_addr (rd_ptr_reg),
    .rd_data (out_data)
  );

  assign level    = level_reg;
  assign overflow = overflow_reg;
  assign chk      = chk_reg;

endmodule

// File: tb/tb_aes_lite_result_fifo.sv
// Bench for aes_lite_result_fifo: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_aes_lite_result_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic              clr_ovf;
  logic [DATA_W-1:0] chk;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // Reference model state
  logic [DATA_W-1:0] m_q[$];
  logic              m_prev = 1'b1;
  logic              m_ovf  = 1'b0;
  logic [DATA_W-1:0] m_chk  = '0;

  always #5 clk = ~clk;

  aes_lite_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .res_data  (res_data),
    .res_ready (res_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .chk       (chk)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the same rules, then compare.
  task automatic cyc(input logic r, input logic rr, input logic [DATA_W-1:0] d,
                     input logic ordy, input logic clr);
    logic push, pop, full_before;
    rst = r; res_ready = rr; res_data = d; out_ready = ordy; clr_ovf = clr;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_chk  = '0;
      m_prev = 1'b1;
    end else begin
      push        = rr && !m_prev;
      full_before = (m_q.size() == DEPTH);
      pop         = (m_q.size() != 0) && ordy;
      if (pop) begin
        m_chk = m_chk ^ m_q[0];
        void'(m_q.pop_front());
      end
      if (push) begin
        if (full_before && !pop) m_ovf = 1'b1;
        else                     m_q.push_back(d);
      end
      if (!(push && full_before && !pop) && clr) m_ovf = 1'b0;
      m_prev = rr;
    end
    #1;
    check_val("level", 32'(level), 32'(m_q.size()));
    check_val("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check_val("out_data", 32'(out_data), 32'(m_q[0]));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
    check_val("chk", 32'(chk), 32'(m_chk));
  endtask

  task automatic push_byte(input logic [DATA_W-1:0] d);
    cyc(1'b0, 1'b1, d, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; res_ready = 1'b0; res_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;

    // Reset state and single push/pop
    do_reset();
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_valid", 32'(out_valid), 32'd0);
    cyc(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    check_val("a5_level", 32'(level), 32'd1);
    check_val("a5_data", 32'(out_data), 32'hA5);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_val("a5_chk", 32'(chk), 32'hA5);
    check_val("a5_empty", 32'(level), 32'd0);

    // Held-high ready pushes only once
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    check_val("held_level", 32'(level), 32'd1);

    // Overflow on the fifth result
    do_reset();
    for (int i = 1; i <= 5; i++) push_byte(8'(i * 8'h11));
    check_val("ovf_level", 32'(level), 32'd4);
    check_val("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_val("ovf_chk", 32'(chk), 32'h44);

    // Push and pop together while full
    do_reset();
    for (int i = 1; i <= 4; i++) push_byte(8'(i * 8'h10));
    cyc(1'b0, 1'b1, 8'h99, 1'b1, 1'b0);
    check_val("fullpp_level", 32'(level), 32'd4);
    check_val("fullpp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_val("fullpp_last", 32'(out_data), 32'h99);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Set wins over clear, then clear alone
    do_reset();
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    cyc(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
    check_val("setwins_ovf", 32'(overflow), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check_val("clr_ovf", 32'(overflow), 32'd0);

    // Mid-operation reset with ready held through release
    do_reset();
    for (int i = 0; i < 3; i++) push_byte(8'(8'hC0 + i));
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
    check_val("mid_rst_level", 32'(level), 32'd0);
    check_val("mid_rst_chk", 32'(chk), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    check_val("rel_nopush", 32'(level), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
          8'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/aes_lite_result_fifo.md
AES_LITE_RESULT_FIFO -- requirements
Module: aes_lite_result_fifo

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DATA_W SHALL default to 8: byte width of the encrypted result.
REQ-003 Parameter DEPTH SHALL default to 4: FIFO entries, a power of two, at least 2.
REQ-004 Port clk SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-006 Port res_data SHALL be an input, DATA_W bits: encrypted byte from the AES-lite core (its data_out).
REQ-007 Port res_ready SHALL be an input, 1 bit: the core's ready level, held high while the result is valid.
REQ-008 Port out_data SHALL be an output, DATA_W bits: head-of-FIFO byte.
REQ-009 Port out_valid SHALL be an output, 1 bit: the FIFO is non-empty.
REQ-010 Port out_ready SHALL be an input, 1 bit: the consumer accepts out_data.
REQ-011 Port level SHALL be an output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-012 Port overflow SHALL be an output, 1 bit: sticky flag set when a result was dropped.
REQ-013 Port clr_ovf SHALL be an input, 1 bit: clears overflow.
REQ-014 Port chk SHALL be an output, DATA_W bits: running XOR of all popped bytes.

Function
REQ-015 Push request SHALL fire on the rising edge of res_ready: previous-cycle res_ready=0 and current res_ready=1.
REQ-016 A res_ready held high SHALL NOT produce further pushes.
REQ-017 The edge-detect register SHALL reset to 1, so a res_ready already high at reset release produces no push.
REQ-018 On a push, the block SHALL store res_data sampled in the same cycle the edge is detected.
REQ-019 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-020 out_data SHALL always present the oldest entry (first-word fall-through): a byte pushed at edge N is visible at out_data/out_valid after edge N.
REQ-021 Push with level<DEPTH SHALL write the entry and increment level.
REQ-022 Pop SHALL advance the read pointer and decrement level.
REQ-023 Simultaneous push and pop SHALL leave level unchanged and accept both, including when level=DEPTH.
REQ-024 Push when level=DEPTH with no pop SHALL drop the byte, leave the FIFO and level unchanged, and set overflow.
REQ-025 out_ready with out_valid=0 SHALL have no effect; level SHALL never underflow.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 chk SHALL become chk XOR popped byte on every pop and SHALL be unchanged otherwise.
REQ-028 clr_ovf=1 SHALL clear overflow next cycle.
REQ-029 If clr_ovf and an overflow event coincide, overflow SHALL be set (set wins).
REQ-030 Control states SHALL be EMPTY (level=0), PARTIAL and FULL (level=DEPTH).
REQ-031 State transitions SHALL follow level only; EMPTY to FULL is possible only via PARTIAL, except when DEPTH=1 (disallowed).

Reset
REQ-032 While rst=1 at a clock edge, the block SHALL clear the pointers and level.
REQ-033 While rst=1 at a clock edge, out_valid SHALL be 0, overflow 0, chk 0 and state EMPTY.
REQ-034 Storage contents need not reset; out_data SHALL be don't-care while out_valid=0.
REQ-035 Reset asserted mid-operation SHALL discard all queued bytes, and any push or pop in that cycle SHALL be ignored.

Structure
REQ-036 Shared package aes_lite_pkg SHALL hold AES_LITE_DATA_W=8, AES_LITE_FIFO_DEPTH=4 and the FIFO state enumeration type.
REQ-037 One sub-module, aes_lite_fifo_mem, SHALL be used: DEPTH x DATA_W register array, one write port, async read.
REQ-038 Edge detect, pointers, level, flags and chk SHALL live in the top module.

Verification
REQ-039 Reset then one res_ready 0→1 with res_data=0xA5: level=1, out_valid=1, out_data=0xA5; pop with out_ready → level=0, chk=0xA5.
REQ-040 res_ready held high 5 cycles with res_data=0x3C: exactly one push, level=1.
REQ-041 Five results 0x11,0x22,0x33,0x44,0x55 with out_ready=0: level=4, overflow=1, pops return 0x11..0x44, chk=0x44.
REQ-042 Full FIFO with a push edge and pop in the same cycle: level stays 4, overflow stays 0, and the new byte is returned last.
REQ-043 overflow=1 with clr_ovf and a new dropped push in the same cycle: overflow remains 1; clr_ovf alone next cycle → 0.
REQ-044 Three bytes queued, then rst=1 for one cycle: level=0, out_valid=0, chk=0x00; res_ready high through reset release yields no push.
